// File: rtl/b_demux_seq.sv
// Time-division 1-to-N demultiplexer: collects lane-ordered serial bits into
// an N-bit parallel word, with a completion strobe and a framing-error strobe.
module b_demux_seq #(
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            d,
   input  logic            v,
   input  logic            sof,
   output logic [N-1:0]    y,
   output logic            yv,
   output logic [SELW-1:0] s,
   output logic            err
);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   localparam logic [SELW-1:0] LAST_LANE = SELW'(N - 1);
   localparam logic [SELW-1:0] LANE_ONE  = SELW'(1);

   state_t          r_state;
   logic [SELW-1:0] r_s;
   logic [N-2:0]    r_shadow;
   logic [N-1:0]    r_y;
   logic            r_yv;
   logic            r_err;

   state_t          w_state_nxt;
   logic [SELW-1:0] w_s_nxt;
   logic [N-2:0]    w_shadow_nxt;
   logic [N-1:0]    w_y_nxt;
   logic            w_yv_nxt;
   logic            w_err_nxt;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_s      <= '0;
         r_shadow <= '0;
         r_y      <= '0;
         r_yv     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_s      <= w_s_nxt;
         r_shadow <= w_shadow_nxt;
         r_y      <= w_y_nxt;
         r_yv     <= w_yv_nxt;
         r_err    <= w_err_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_s_nxt      = r_s;
      w_shadow_nxt = r_shadow;
      w_y_nxt      = r_y;
      w_yv_nxt     = 1'b0;
      w_err_nxt    = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (v && sof) begin
               w_shadow_nxt[0] = d;
               w_s_nxt         = LANE_ONE;
               w_state_nxt     = FILL;
            end
         end
         FILL: begin
            if (v) begin
               if (sof) begin
                  // A sof anywhere but lane 0 aborts the partial frame
                  w_err_nxt       = (r_s != '0);
                  w_shadow_nxt[0] = d;
                  w_s_nxt         = LANE_ONE;
               end else if (r_s == LAST_LANE) begin
                  w_y_nxt  = {d, r_shadow};
                  w_yv_nxt = 1'b1;
                  w_s_nxt  = '0;
               end else begin
                  for (int unsigned k = 0; k < N - 1; k++) begin
                     if (r_s == SELW'(k)) w_shadow_nxt[k] = d;
                  end
                  w_s_nxt = r_s + LANE_ONE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign y   = r_y;
   assign yv  = r_yv;
   assign s   = r_s;
   assign err = r_err;

endmodule

// File: doc/b_demux_seq.md
Name: b_demux_seq

Overview:
- Sequential 1-to-N time-division demultiplexer and deserializer.
- Receives the single-bit lane-multiplexed stream produced by the team's 2:1/N:1 select-driven multiplexers and routes bit k of each frame to lane k.
- Presents each completed frame as a registered N-bit parallel word with a one-cycle valid strobe.
- Sits at the receive end of the muxed link, between the serial wire and the parallel consumer logic.

Parameters:
- N, 4, number of lanes (bits per frame); legal range 2..16.
- SELW, 2, width of the lane index; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- d  input  1  serial data bit for the current lane.
- v  input  1  d is valid this cycle; the bit is consumed only when v=1.
- sof  input  1  start of frame; qualified by v; marks d as lane 0.
- y  output  N  last completed frame; y[k] is lane k.
- yv  output  1  one-cycle strobe: y was updated on the previous edge.
- s  output  SELW  lane index the next accepted bit will be written to.
- err  output  1  one-cycle strobe: framing error (frame restarted before completion).

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n). All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, s=0, y=0, yv=0, err=0.
  - Internal shadow register cleared to 0.
  - rst_n overrides every other input, including mid-frame; a partial frame is discarded with no yv and no err.
- State machine states: IDLE, FILL.
- IDLE:
  - v=0, or v=1 with sof=0: bit dropped; stay in IDLE; s stays 0.
  - v=1 with sof=1: shadow[0]=d; s=1; go to FILL.
- FILL:
  - v=0: hold all state; s unchanged. Gaps of any length are allowed.
  - v=1, sof=0, s<N-1: shadow[s]=d; s=s+1.
  - v=1, sof=0, s=N-1:
    - y = {d, shadow[N-2:0]}; yv=1 in the following cycle; s wraps to 0.
    - Stay in FILL: back-to-back frames do not require sof. A sof on the next lane-0 bit is legal and not an error.
  - v=1, sof=1, s=0: normal frame start; shadow[0]=d; s=1.
  - v=1, sof=1, s!=0 (early sof):
    - err=1 for one cycle; partial frame discarded; y unchanged; no yv.
    - shadow[0]=d; s=1. The new frame starts with this bit.
- Strobes:
  - yv and err default to 0 every cycle. They cannot both be 1 in the same cycle.
  - Latency: the last bit is sampled at edge t; y/yv are visible after edge t.
- Width and wrap rules:
  - s counts 0..N-1 and wraps to 0, never reaching N; compare against N-1, not 2^SELW-1.
  - Lane ordering: first accepted bit of a frame goes to y[0], last to y[N-1].
- Non-power-of-2 N (e.g. N=3, SELW=2): index 3 is never reachable.
- y holds its value until the next completed frame or reset.

Test Plan:
- Reset, then rst_n=1 idle for 5 cycles -> y=0, yv=0, err=0, s=0 throughout.
- N=4: v=1 for 4 consecutive cycles, sof=1 on the first, d=1,0,1,1 -> after the 4th edge y=4'b1101 and yv=1 for exactly one cycle; s=0.
- Same frame with v=0 gaps of 3 cycles between each bit -> same y=4'b1101; single yv pulse; s stalls during gaps.
- Back-to-back frames: d=1,1,0,0 then 0,1,0,1 with sof only on the first bit -> yv pulses at cycles 4 and 8; y=4'b0011 then 4'b1010.
- Early sof: 2 bits accepted, then v=1, sof=1, d=0, followed by 3 more bits 1,1,1 -> err=1 for one cycle on the restart; then y=4'b1110 with yv=1; no yv for the aborted frame.
- Bits with v=1, sof=0 in IDLE -> ignored; y and s unchanged. Then rst_n=0 asserted mid-frame with s=2 -> next cycle s=0, y=0, no yv or err.
